mem_access: RTL
===============

# mem_access

Load/store unit of the MEM pipeline stage. It takes one instruction per cycle from the EX/MEM latch and passes non-memory results straight to write-back. Loads and stores become a single held request to the memory controller's data port. The unit stalls the pipeline until the controller signals completion, then sign/zero-extends load data and presents it to write-back.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, register/data width
- clk_in  input  1  clock; all state updates on posedge
- rst_in  input  1  asynchronous, active-low reset
- rdy_in  input  1  global enable; low freezes all state and outputs
- ex_valid_in  input  1  instruction present from EX
- ex_is_load_in / ex_is_store_in  input  1 each  memory operation kind
- ex_funct3_in  input  3  RV32I width/sign code
- ex_addr_in  input  ADDR_W  effective address
- ex_store_val_in  input  DATA_W  rs2 value for stores
- ex_rd_in  input  5  destination register
- ex_wb_val_in  input  DATA_W  ALU result for non-memory instructions
- read_req_out / write_req_out  output  1 each  request to memory controller, held until done
- mem_addr_out  output  ADDR_W  request address
- mem_val_out  output  DATA_W  store data, low bytes significant
- mem_len_out  output  2  bytes minus one: 0=byte, 1=half, 3=word
- mem_done_in  input  1  one-cycle completion pulse from controller
- mem_val_read_in  input  DATA_W  little-endian read data, valid with mem_done_in
- stall_req_out  output  1  combinational stall to pipeline control
- wb_valid_out  output  1  write-back entry valid
- wb_rd_out  output  5  write-back register
- wb_val_out  output  DATA_W  write-back value

## Operation
- States: IDLE, WAIT.
- IDLE, ex_valid_in, neither load nor store:
  - register wb_valid_out=1, wb_rd_out=ex_rd_in, wb_val_out=ex_wb_val_in.
  - If rd=0, wb_valid_out=0.
- IDLE, legal load or store:
  - latch addr, funct3, rd, and store data.
  - Assert read_req_out or write_req_out from the next cycle; go to WAIT.
  - Clear wb_valid_out.
- Legal funct3:
  - loads: LB=000, LH=001, LW=010, LBU=100, LHU=101
  - stores: SB=000, SH=001, SW=010
- Illegal funct3: no request is issued; the instruction is treated as a bubble (wb_valid_out=0).
- Load and store both asserted: treated as a load.
- WAIT:
  - Request, address, data and length stay constant until mem_done_in.
  - On mem_done_in, drop the request next cycle and return to IDLE.
  - Load on mem_done_in: wb_valid_out=1 (0 if rd=0), wb_val_out = extended data.
  - Store on mem_done_in: wb_valid_out=0.
- Load extension: LB sign-extends [7:0]; LH sign-extends [15:0]; LBU/LHU zero-extend; LW passes all 32 bits.
- Misaligned addresses are legal: the controller transfers byte-serially, and no trap is raised.
- mem_done_in in IDLE is ignored.

## Timing
- Reset values: all request outputs 0, mem_addr_out 0, mem_val_out 0, mem_len_out 0, wb_* 0, state IDLE.
- Non-memory instructions: 1-cycle latency, no stall.
- stall_req_out is high when either holds:
  - IDLE with a legal memory op at ex_valid_in;
  - WAIT and !mem_done_in.
- stall_req_out falls in the mem_done_in cycle, so the next instruction is accepted on the following edge.
- Load: wb_valid_out rises on the edge after mem_done_in. Total latency is 1 + controller latency + 1 cycles.
- rdy_in low:
  - no state change;
  - requests remain asserted;
  - a mem_done_in pulse arriving while rdy_in is low is lost, so the controller must share rdy_in.
- Asynchronous reset mid-WAIT: request deasserts immediately and state becomes IDLE. The controller is reset by the same signal.

## Structure
- Shared package holds:
  - funct3 load/store encodings;
  - mem_len codes (LEN_B=0, LEN_H=1, LEN_W=3);
  - state enum {IDLE, WAIT}.
- One combinational sub-module, mem_load_ext (funct3, raw data -> extended data), reusable by the forwarding path.

## Test plan
- Reset, then a non-memory instruction with rd=5 and value 0x1234 -> wb_valid_out=1, wb_rd_out=5, wb_val_out=0x1234 one cycle later, stall_req_out never high.
- LB at 0x1003, controller returns 0x000000F0 after 4 cycles -> read_req_out held all 4 cycles, wb_val_out=0xFFFFFFF0, stall_req_out drops in the done cycle.
- LHU then LH, both returning 0x00008001 -> wb_val_out 0x00008001, then 0xFFFF8001.
- SH with rs2=0xDEADBEEF at 0x2002 -> write_req_out=1, mem_len_out=1, mem_val_out=0xDEADBEEF held until done; wb_valid_out stays 0.
- Load in WAIT with rdy_in low for 3 cycles, then done -> outputs frozen during the pause, correct completion afterwards; a second run asserts rst_in low mid-WAIT -> read_req_out=0 immediately, state IDLE.
- Illegal funct3=011 load and an LW with rd=0 -> no request for the first; the second issues a request but wb_valid_out stays 0.

Source files
------------

// File: rtl/mem_access_pkg.sv
// ============================================================================
// Module      : mem_access_pkg
// Description : Shared encodings for the MEM-stage load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_access_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] LEN_B = 2'd0;
  localparam logic [1:0] LEN_H = 2'd1;
  localparam logic [1:0] LEN_W = 2'd3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  function automatic logic [1:0] len_of(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   len_of = LEN_B;
      2'b01:   len_of = LEN_H;
      default: len_of = LEN_W;
    endcase
  endfunction

  function automatic logic legal_load(input logic [2:0] funct3);
    legal_load = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                 (funct3 == F3_BU) || (funct3 == F3_HU);
  endfunction

  function automatic logic legal_store(input logic [2:0] funct3);
    legal_store = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_load_ext.sv
// ============================================================================
// Module      : mem_load_ext
// Description : Sign/zero extension of raw little-endian load data by funct3.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_load_ext
  import mem_access_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] raw_data,
  output logic [DATA_W-1:0] ext_data
);

  always_comb begin
    ext_data = raw_data;
    case (funct3)
      F3_B:    ext_data = {{(DATA_W-8){raw_data[7]}}, raw_data[7:0]};
      F3_H:    ext_data = {{(DATA_W-16){raw_data[15]}}, raw_data[15:0]};
      F3_BU:   ext_data = {{(DATA_W-8){1'b0}}, raw_data[7:0]};
      F3_HU:   ext_data = {{(DATA_W-16){1'b0}}, raw_data[15:0]};
      default: ext_data = raw_data;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access.sv
// ============================================================================
// Module      : mem_access
// Description : MEM-stage load/store unit with a held memory request.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              ex_valid_in,
  input  logic              ex_is_load_in,
  input  logic              ex_is_store_in,
  input  logic [2:0]        ex_funct3_in,
  input  logic [ADDR_W-1:0] ex_addr_in,
  input  logic [DATA_W-1:0] ex_store_val_in,
  input  logic [4:0]        ex_rd_in,
  input  logic [DATA_W-1:0] ex_wb_val_in,
  output logic              read_req_out,
  output logic              write_req_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [DATA_W-1:0] mem_val_out,
  output logic [1:0]        mem_len_out,
  input  logic              mem_done_in,
  input  logic [DATA_W-1:0] mem_val_read_in,
  output logic              stall_req_out,
  output logic              wb_valid_out,
  output logic [4:0]        wb_rd_out,
  output logic [DATA_W-1:0] wb_val_out
);

  state_t              r_state, w_state_nxt;
  logic                r_is_load, w_is_load_nxt;
  logic [2:0]          r_funct3, w_funct3_nxt;
  logic [4:0]          r_rd, w_rd_nxt;
  logic                w_read_nxt, w_write_nxt;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic [DATA_W-1:0]   w_val_nxt;
  logic [1:0]          w_len_nxt;
  logic                w_wb_valid_nxt;
  logic [4:0]          w_wb_rd_nxt;
  logic [DATA_W-1:0]   w_wb_val_nxt;
  logic [DATA_W-1:0]   w_ext_data;
  logic                w_mem_op;

  // A simultaneous load+store is a load, so store legality only matters alone.
  assign w_mem_op = ex_valid_in &&
                    ((ex_is_load_in && legal_load(ex_funct3_in)) ||
                     (!ex_is_load_in && ex_is_store_in && legal_store(ex_funct3_in)));

  mem_load_ext #(.DATA_W(DATA_W)) u_load_ext (
    .funct3   (r_funct3),
    .raw_data (mem_val_read_in),
    .ext_data (w_ext_data)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state       <= IDLE;
      r_is_load     <= 1'b0;
      r_funct3      <= 3'd0;
      r_rd          <= 5'd0;
      read_req_out  <= 1'b0;
      write_req_out <= 1'b0;
      mem_addr_out  <= '0;
      mem_val_out   <= '0;
      mem_len_out   <= 2'd0;
      wb_valid_out  <= 1'b0;
      wb_rd_out     <= 5'd0;
      wb_val_out    <= '0;
    end else if (rdy_in) begin
      r_state       <= w_state_nxt;
      r_is_load     <= w_is_load_nxt;
      r_funct3      <= w_funct3_nxt;
      r_rd          <= w_rd_nxt;
      read_req_out  <= w_read_nxt;
      write_req_out <= w_write_nxt;
      mem_addr_out  <= w_addr_nxt;
      mem_val_out   <= w_val_nxt;
      mem_len_out   <= w_len_nxt;
      wb_valid_out  <= w_wb_valid_nxt;
      wb_rd_out     <= w_wb_rd_nxt;
      wb_val_out    <= w_wb_val_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_is_load_nxt  = r_is_load;
    w_funct3_nxt   = r_funct3;
    w_rd_nxt       = r_rd;
    w_read_nxt     = read_req_out;
    w_write_nxt    = write_req_out;
    w_addr_nxt     = mem_addr_out;
    w_val_nxt      = mem_val_out;
    w_len_nxt      = mem_len_out;
    w_wb_valid_nxt = 1'b0;
    w_wb_rd_nxt    = wb_rd_out;
    w_wb_val_nxt   = wb_val_out;
    stall_req_out  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_mem_op) begin
          stall_req_out = 1'b1;
          w_state_nxt   = WAIT;
          w_is_load_nxt = ex_is_load_in;
          w_read_nxt    = ex_is_load_in;
          w_write_nxt   = !ex_is_load_in;
          w_funct3_nxt  = ex_funct3_in;
          w_rd_nxt      = ex_rd_in;
          w_addr_nxt    = ex_addr_in;
          w_val_nxt     = ex_store_val_in;
          w_len_nxt     = len_of(ex_funct3_in);
        end else if (ex_valid_in && !ex_is_load_in && !ex_is_store_in) begin
          w_wb_valid_nxt = (ex_rd_in != 5'd0);
          w_wb_rd_nxt    = ex_rd_in;
          w_wb_val_nxt   = ex_wb_val_in;
        end
      end
      WAIT: begin
        if (mem_done_in) begin
          w_state_nxt = IDLE;
          w_read_nxt  = 1'b0;
          w_write_nxt = 1'b0;
          if (r_is_load) begin
            w_wb_valid_nxt = (r_rd != 5'd0);
            w_wb_rd_nxt    = r_rd;
            w_wb_val_nxt   = w_ext_data;
          end
        end else begin
          stall_req_out = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

`default_nettype wire
